// File: rtl/q_sys_pio_in_edge.sv
// rtl/q_sys_pio_in_edge.sv - Avalon-MM PIO input port with synchronised edge capture and level interrupt
// Build macro: Q_SYS_PIO_IN_BIT_CLEAR_EN (per-bit edgecapture clear on write to address 3)
module q_sys_pio_in_edge #(
    parameter int DATA_W      = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [DATA_W-1:0] in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] data_s;
    logic [DATA_W-1:0] data_dly_q, data_dly_d;
    logic [1:0]        warm_q, warm_d;
    logic              edge_en;
    logic [DATA_W-1:0] edge_det;
    logic [DATA_W-1:0] clear_mask;
    logic [DATA_W-1:0] irqmask_q, irqmask_d;
    logic [DATA_W-1:0] edgecap_q, edgecap_d;
    logic [31:0]       readdata_q, readdata_d;
    logic              irq_q, irq_d;
    logic              wr_en;
    logic              unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign data_s       = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;
    assign readdata     = readdata_q;
    assign irq          = irq_q;

    // Metastability chain: every in_port bit passes through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Warm-up: edge detection is gated until the chain has filled. On the last
    // warm-up cycle the delayed copy is preloaded with the value data_s is about
    // to take, so a level already present at reset release never looks like an edge.
    always_comb begin
        edge_en    = (warm_q == 2'(SYNC_STAGES));
        warm_d     = edge_en ? warm_q : warm_q + 2'd1;
        data_dly_d = edge_en ? data_s : sync_q[SYNC_STAGES-2];
    end

    // Per-bit edge detector selected by EDGE_TYPE.
    always_comb begin
        edge_det = '0;
        if (edge_en) begin
            case (EDGE_TYPE)
                0:       edge_det = data_s & ~data_dly_q;
                1:       edge_det = ~data_s & data_dly_q;
                default: edge_det = data_s ^ data_dly_q;
            endcase
        end
    end

    // Edgecapture clear mask from a write to address 3.
    always_comb begin
        clear_mask = '0;
        if (wr_en && address == 2'd3) begin
`ifdef Q_SYS_PIO_IN_BIT_CLEAR_EN
            clear_mask = writedata[DATA_W-1:0];
`else
            clear_mask = '1;
`endif
        end
    end

    // Register file next state, interrupt and read mux; a new edge beats a clear.
    always_comb begin
        irqmask_d = irqmask_q;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[DATA_W-1:0];
        end
        edgecap_d  = (edgecap_q & ~clear_mask) | edge_det;
        irq_d      = |(edgecap_q & irqmask_q);
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[DATA_W-1:0] = data_s;
            2'd2:    readdata_d[DATA_W-1:0] = irqmask_q;
            2'd3:    readdata_d[DATA_W-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    // State registers for detection, registers and outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_dly_q <= '0;
            warm_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            data_dly_q <= data_dly_d;
            warm_q     <= warm_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

endmodule

// File: tb/tb_q_sys_pio_in_edge.sv
// tb/tb_q_sys_pio_in_edge.sv - self-checking bench for q_sys_pio_in_edge (rising and any-edge instances)
module tb_q_sys_pio_in_edge;

    localparam int SS = 2;
`ifdef Q_SYS_PIO_IN_BIT_CLEAR_EN
    localparam bit BITCLR = 1'b1;
`else
    localparam bit BITCLR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int checks = 0;
    int fails  = 0;

    // reference model state
    int          m_k;
    logic [7:0]  m_samp[$];
    logic [7:0]  m_ds, m_ds_prev, m_mask, m_ec0, m_ec1;
    logic [31:0] m_rd0, m_rd1;
    logic        m_irq0, m_irq1;

    q_sys_pio_in_edge #(.DATA_W(8), .EDGE_TYPE(0), .SYNC_STAGES(SS)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));

    q_sys_pio_in_edge #(.DATA_W(8), .EDGE_TYPE(2), .SYNC_STAGES(SS)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rd_mux(input logic [1:0] a, input logic [7:0] ds,
                                           input logic [7:0] mask, input logic [7:0] ec);
        case (a)
            2'd0:    return {24'h0, ds};
            2'd2:    return {24'h0, mask};
            2'd3:    return {24'h0, ec};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_k = 0; m_samp.delete();
        m_ds = 0; m_ds_prev = 0; m_mask = 0; m_ec0 = 0; m_ec1 = 0;
        m_rd0 = 0; m_rd1 = 0; m_irq0 = 0; m_irq1 = 0;
    endtask

    // One clock edge of the specified behaviour: data_s is in_port delayed by
    // SS samples, edges are ignored for the first SS+1 edges after release.
    task automatic model_edge();
        logic [7:0] det_r, det_a, clr, ds_old;
        if (!reset_n) begin
            model_reset();
            return;
        end
        m_k++;
        m_samp.push_back(in_port);
        ds_old = m_ds;
        det_r  = ds_old & ~m_ds_prev;
        det_a  = ds_old ^ m_ds_prev;
        if (m_k <= SS + 1) begin
            det_r = 8'h00;
            det_a = 8'h00;
        end
        m_irq0 = |(m_ec0 & m_mask);
        m_irq1 = |(m_ec1 & m_mask);
        m_rd0  = rd_mux(address, ds_old, m_mask, m_ec0);
        m_rd1  = rd_mux(address, ds_old, m_mask, m_ec1);
        clr = 8'h00;
        if (chipselect && !write_n && address == 2'd3) clr = BITCLR ? writedata[7:0] : 8'hFF;
        m_ec0 = (m_ec0 & ~clr) | det_r;
        m_ec1 = (m_ec1 & ~clr) | det_a;
        if (chipselect && !write_n && address == 2'd2) m_mask = writedata[7:0];
        m_ds_prev = ds_old;
        m_ds = (m_k >= SS) ? m_samp[m_k-SS] : 8'h00;
    endtask

    // Drive one cycle of inputs, advance one clock, return at the falling edge.
    task automatic step(input logic [1:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input logic [7:0] pin);
        address = a; chipselect = cs; write_n = wn; writedata = wd; in_port = pin;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        step(2'd0, 1'b0, 1'b1, 32'h0, 8'h00);
        step(2'd0, 1'b0, 1'b1, 32'h0, 8'h00);
        checks++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin fails++; $display("FAIL reset_readdata: got %h/%h expected 0", rd0, rd1); end
        checks++; if (irq0 !== 1'b0 || irq1 !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b/%b expected 0", irq0, irq1); end
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            step(2'(a), 1'b0, 1'b1, 32'h0, 8'h00);
            step(2'(a), 1'b0, 1'b1, 32'h0, 8'h00);
            checks++; if (rd0 !== 32'h0) begin fails++; $display("FAIL reset_reg_%0d: got %h expected 0", a, rd0); end
        end
        for (int i = 0; i < 4; i++) step(2'd0, 1'b0, 1'b1, 32'h0, 8'h00);
    endtask

    task automatic test_data_read();
        int n = 0;
        for (int i = 1; i <= 6; i++) begin
            step(2'd0, 1'b0, 1'b1, 32'h0, 8'h5A);
            if (n == 0 && rd0 === 32'h0000005A) n = i;
            checks++; if (rd0 !== m_rd0) begin fails++; $display("FAIL data_read_model: got %h expected %h", rd0, m_rd0); end
        end
        checks++; if (n == 0 || n > 3) begin fails++; $display("FAIL data_read_latency: got %0d cycles expected at most 3", n); end
    endtask

    task automatic test_rise_irq();
        int n_ec = 0, n_irq = 0;
        step(2'd2, 1'b1, 1'b0, 32'h01, 8'h5A);
        step(2'd3, 1'b1, 1'b0, 32'hFF, 8'h5A);
        for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h5A);
        checks++; if (rd0 !== 32'h0) begin fails++; $display("FAIL rise_pre_clear: got %h expected 0", rd0); end
        for (int i = 1; i <= 8; i++) begin
            step(2'd3, 1'b0, 1'b1, 32'h0, 8'h5B);
            if (n_ec == 0 && rd0[0] === 1'b1) n_ec = i;
            if (n_irq == 0 && irq0 === 1'b1) n_irq = i;
            checks++; if (rd0 !== m_rd0 || irq0 !== m_irq0) begin fails++; $display("FAIL rise_model: got %h/%b expected %h/%b", rd0, irq0, m_rd0, m_irq0); end
        end
        checks++; if (n_ec != 4) begin fails++; $display("FAIL rise_capture_latency: got %0d expected 4 (set at 3, read 1 later)", n_ec); end
        checks++; if (n_irq != 4) begin fails++; $display("FAIL rise_irq_latency: got %0d expected 4", n_irq); end
        step(2'd3, 1'b1, 1'b0, 32'hFF, 8'h5B);
        for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h5B);
        for (int i = 0; i < 6; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h5A);
        checks++; if (rd0 !== 32'h0) begin fails++; $display("FAIL fall_no_capture_rise_mode: got %h expected 0", rd0); end
        checks++; if (rd1 !== 32'h1) begin fails++; $display("FAIL fall_capture_any_mode: got %h expected 1", rd1); end
        checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL fall_irq: got %b expected 0", irq0); end
    endtask

    task automatic test_any_edge_clear();
        step(2'd2, 1'b1, 1'b0, 32'h08, 8'h00);
        for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        step(2'd3, 1'b1, 1'b0, 32'hFF, 8'h00);
        for (int i = 0; i < 3; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h08);
        for (int i = 0; i < 6; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        checks++; if (rd1 !== 32'h08) begin fails++; $display("FAIL any_edge_capture: got %h expected 08", rd1); end
        checks++; if (irq1 !== 1'b1) begin fails++; $display("FAIL any_edge_irq: got %b expected 1", irq1); end
        step(2'd3, 1'b1, 1'b0, 32'h08, 8'h00);
        checks++; if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_hold_after_clear: got %b expected 1", irq1); end
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        checks++; if (irq1 !== 1'b0) begin fails++; $display("FAIL irq_drop_2_cycles: got %b expected 0", irq1); end
        checks++; if (rd1 !== 32'h0) begin fails++; $display("FAIL any_edge_cleared: got %h expected 0", rd1); end
    endtask

    task automatic test_bit_clear();
        logic [31:0] exp;
        exp = BITCLR ? 32'h02 : 32'h00;
        for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h03);
        checks++; if (rd0 !== 32'h03) begin fails++; $display("FAIL bit_clear_setup: got %h expected 03", rd0); end
        step(2'd3, 1'b1, 1'b0, 32'h01, 8'h03);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'h03);
        checks++; if (rd0 !== exp) begin fails++; $display("FAIL bit_clear_result: got %h expected %h", rd0, exp); end
    endtask

    task automatic test_set_wins();
        for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        step(2'd3, 1'b1, 1'b0, 32'hFF, 8'h00);
        for (int i = 0; i < 3; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'h00);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'h01);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'h01);
        step(2'd3, 1'b1, 1'b0, 32'h01, 8'h01);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'h01);
        checks++; if (rd0 !== 32'h01) begin fails++; $display("FAIL set_wins_over_clear: got %h expected 01", rd0); end
        checks++; if (rd0 !== m_rd0) begin fails++; $display("FAIL set_wins_model: got %h expected %h", rd0, m_rd0); end
    endtask

    task automatic test_reset_mid();
        step(2'd2, 1'b1, 1'b0, 32'hFF, 8'hFF);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
        reset_n = 1'b0;
        model_reset();
        step(2'd0, 1'b0, 1'b1, 32'h0, 8'hFF);
        checks++; if (rd0 !== 32'h0 || rd1 !== 32'h0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h/%h/%b/%b expected all 0", rd0, rd1, irq0, irq1); end
        step(2'd0, 1'b0, 1'b1, 32'h0, 8'hFF);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
            checks++; if (rd0 !== 32'h0 || rd1 !== 32'h0 || irq0 !== 1'b0 || irq1 !== 1'b0) begin
                fails++; $display("FAIL warmup_no_capture: got %h/%h/%b/%b expected all 0", rd0, rd1, irq0, irq1); end
        end
        step(2'd2, 1'b0, 1'b1, 32'h0, 8'hFF);
        step(2'd2, 1'b0, 1'b1, 32'h0, 8'hFF);
        checks++; if (rd0 !== 32'h0) begin fails++; $display("FAIL reset_mask_cleared: got %h expected 0", rd0); end
        for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFE);
        for (int i = 0; i < 5; i++) step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
        checks++; if (rd0 !== 32'h01) begin fails++; $display("FAIL post_reset_new_edge: got %h expected 01", rd0); end
        checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL post_reset_masked_irq: got %b expected 0", irq0); end
        step(2'd2, 1'b1, 1'b0, 32'h01, 8'hFF);
        step(2'd3, 1'b0, 1'b1, 32'h0, 8'hFF);
        checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL post_reset_unmasked_irq: got %b expected 1", irq0); end
    endtask

    task automatic test_random();
        logic [7:0] pin;
        pin = 8'hFF;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 $urandom, pin);
            checks++; if (rd0 !== m_rd0) begin fails++; $display("FAIL random_rd_rise @%0d: got %h expected %h", i, rd0, m_rd0); end
            checks++; if (rd1 !== m_rd1) begin fails++; $display("FAIL random_rd_any @%0d: got %h expected %h", i, rd1, m_rd1); end
            checks++; if (irq0 !== m_irq0) begin fails++; $display("FAIL random_irq_rise @%0d: got %b expected %b", i, irq0, m_irq0); end
            checks++; if (irq1 !== m_irq1) begin fails++; $display("FAIL random_irq_any @%0d: got %b expected %b", i, irq1, m_irq1); end
        end
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'h0; in_port = 8'h00;
        model_reset();
        @(negedge clk);
        test_reset();
        test_data_read();
        test_rise_irq();
        test_any_edge_clear();
        test_bit_clear();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
